// File: rtl/sketch_hot_filter.sv
// sketch_hot_filter: combines count-min sketch lane reads into a min estimate,
// flags hot keys against a threshold, suppresses recently reported keys and
// queues the survivors in a first-word-fall-through FIFO for the reporter.
module sketch_hot_filter #(
  parameter int NUM_LANES    = 4,
  parameter int KEY_WIDTH    = 32,
  parameter int CNT_WIDTH    = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int DEDUP_DEPTH  = 8,
  parameter int EPOCH_CYCLES = 65536
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable_i,
  input  logic                           clear_i,
  input  logic [CNT_WIDTH-1:0]           threshold_i,
  input  logic [NUM_LANES-1:0]           lane_valid_i,
  input  logic [NUM_LANES*CNT_WIDTH-1:0] lane_cnt_i,
  input  logic [KEY_WIDTH-1:0]           lane_key_i,
  output logic                           hot_valid_o,
  input  logic                           hot_ready_i,
  output logic [KEY_WIDTH-1:0]           hot_key_o,
  output logic [CNT_WIDTH-1:0]           hot_cnt_o,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level_o,
  output logic [31:0]                    drop_cnt_o,
  output logic [31:0]                    misalign_cnt_o,
  output logic [31:0]                    hot_total_o
);

  localparam int LW  = $clog2(FIFO_DEPTH);
  localparam int DW  = (DEDUP_DEPTH > 1) ? $clog2(DEDUP_DEPTH) : 1;
  localparam int EW  = $clog2(EPOCH_CYCLES);

  typedef enum logic {RUN, IDLE} state_t;

  state_t state, next_state;
  logic   epoch_run;

  logic                 s1_valid;
  logic [CNT_WIDTH-1:0] s1_min;
  logic [KEY_WIDTH-1:0] s1_key;

  logic [CNT_WIDTH-1:0] lane_min;
  logic                 all_valid, partial_valid;

  logic [KEY_WIDTH-1:0] fifo_key [FIFO_DEPTH];
  logic [CNT_WIDTH-1:0] fifo_cnt [FIFO_DEPTH];
  logic [LW-1:0]        rd_ptr, wr_ptr;
  logic [LW:0]          level;

  logic [KEY_WIDTH-1:0]   dedup_key [DEDUP_DEPTH];
  logic [DEDUP_DEPTH-1:0] dedup_valid;
  logic [DW-1:0]          dedup_ptr;
  logic [EW-1:0]          epoch;

  logic candidate, dedup_hit, fifo_full, do_push, do_drop, do_pop, epoch_wrap;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Control state register: RUN while detection is enabled, IDLE otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= next_state;
  end

  // Next-state logic; the epoch timer only advances while in RUN.
  always_comb begin
    next_state = state;
    epoch_run  = 1'b0;
    case (state)
      RUN: begin
        epoch_run = 1'b1;
        if (!enable_i) next_state = IDLE;
      end
      IDLE: begin
        if (enable_i) next_state = RUN;
      end
      default: next_state = RUN;
    endcase
  end

  // Unsigned minimum over all lane counters plus lane-valid alignment check.
  always_comb begin
    lane_min = lane_cnt_i[CNT_WIDTH-1:0];
    for (int i = 1; i < NUM_LANES; i++) begin
      if (lane_cnt_i[i*CNT_WIDTH +: CNT_WIDTH] < lane_min)
        lane_min = lane_cnt_i[i*CNT_WIDTH +: CNT_WIDTH];
    end
    all_valid     = &lane_valid_i;
    partial_valid = (|lane_valid_i) && !all_valid;
  end

  // Stage 1 register: aligned access, its min estimate and key.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_min   <= '0;
      s1_key   <= '0;
    end else begin
      s1_valid <= all_valid;
      s1_min   <= lane_min;
      s1_key   <= lane_key_i;
    end
  end

  // Stage 2 decision: threshold test, dedup lookup, push/drop/pop and epoch wrap.
  always_comb begin
    candidate = s1_valid && enable_i && (threshold_i != '0) && (s1_min >= threshold_i);
    dedup_hit = 1'b0;
    for (int i = 0; i < DEDUP_DEPTH; i++) begin
      if (dedup_valid[i] && (dedup_key[i] == s1_key)) dedup_hit = 1'b1;
    end
    fifo_full  = (level == (LW+1)'(FIFO_DEPTH));
    do_push    = candidate && !dedup_hit && !fifo_full && !clear_i;
    do_drop    = candidate && !dedup_hit && fifo_full && !clear_i;
    do_pop     = hot_valid_o && hot_ready_i;
    epoch_wrap = epoch_run && (epoch == EW'(EPOCH_CYCLES - 1));
  end

  // FIFO pointers and occupancy; clear empties the queue.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + LW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + LW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (LW+1)'(1);
        2'b01:   level <= level - (LW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // FIFO storage; contents need no reset because occupancy gates the head.
  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_key[wr_ptr] <= s1_key;
      fifo_cnt[wr_ptr] <= s1_min;
    end
  end

  // Dedup table: epoch wrap invalidates everything except an entry inserted the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      dedup_valid <= '0;
      dedup_ptr   <= '0;
    end else begin
      if (epoch_wrap) dedup_valid <= '0;
      if (do_push) begin
        dedup_valid[dedup_ptr] <= 1'b1;
        dedup_ptr <= (dedup_ptr == DW'(DEDUP_DEPTH - 1)) ? '0 : dedup_ptr + DW'(1);
      end
    end
  end

  // Dedup key storage, only meaningful where the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (do_push) dedup_key[dedup_ptr] <= s1_key;
  end

  // Epoch timer, frozen in IDLE, wraps at the epoch length.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) epoch <= '0;
    else if (epoch_wrap)   epoch <= '0;
    else if (epoch_run)    epoch <= epoch + EW'(1);
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      hot_total_o    <= '0;
      drop_cnt_o     <= '0;
      misalign_cnt_o <= '0;
    end else begin
      if (do_push)       hot_total_o    <= sat_inc(hot_total_o);
      if (do_drop)       drop_cnt_o     <= sat_inc(drop_cnt_o);
      if (partial_valid) misalign_cnt_o <= sat_inc(misalign_cnt_o);
    end
  end

  assign hot_valid_o  = (level != '0);
  assign hot_key_o    = hot_valid_o ? fifo_key[rd_ptr] : '0;
  assign hot_cnt_o    = hot_valid_o ? fifo_cnt[rd_ptr] : '0;
  assign fifo_level_o = level;

endmodule

// File: tb/tb_sketch_hot_filter.sv
// Self-checking bench for sketch_hot_filter: table vectors, directed
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_sketch_hot_filter;

  localparam int NL = 4;
  localparam int KW = 32;
  localparam int CW = 16;
  localparam int FD = 16;
  localparam int DD = 8;
  localparam int EP = 64;
  localparam int LVW = $clog2(FD) + 1;

  logic              clk;
  logic              rst_n;
  logic              enable_i;
  logic              clear_i;
  logic [CW-1:0]     threshold_i;
  logic [NL-1:0]     lane_valid_i;
  logic [NL*CW-1:0]  lane_cnt_i;
  logic [KW-1:0]     lane_key_i;
  logic              hot_valid_o;
  logic              hot_ready_i;
  logic [KW-1:0]     hot_key_o;
  logic [CW-1:0]     hot_cnt_o;
  logic [LVW-1:0]    fifo_level_o;
  logic [31:0]       drop_cnt_o;
  logic [31:0]       misalign_cnt_o;
  logic [31:0]       hot_total_o;

  sketch_hot_filter #(
    .NUM_LANES(NL), .KEY_WIDTH(KW), .CNT_WIDTH(CW),
    .FIFO_DEPTH(FD), .DEDUP_DEPTH(DD), .EPOCH_CYCLES(EP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .clear_i(clear_i),
    .threshold_i(threshold_i), .lane_valid_i(lane_valid_i),
    .lane_cnt_i(lane_cnt_i), .lane_key_i(lane_key_i),
    .hot_valid_o(hot_valid_o), .hot_ready_i(hot_ready_i),
    .hot_key_o(hot_key_o), .hot_cnt_o(hot_cnt_o),
    .fifo_level_o(fifo_level_o), .drop_cnt_o(drop_cnt_o),
    .misalign_cnt_o(misalign_cnt_o), .hot_total_o(hot_total_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: queue of {key,min}, recent-key table, counters.
  logic [KW+CW-1:0] mq[$];
  logic [KW-1:0]    md_key [DD];
  bit               md_val [DD];
  int               md_ptr;
  int               m_epoch;
  bit               m_run;
  bit               m_s1_valid;
  logic [CW-1:0]    m_s1_min;
  logic [KW-1:0]    m_s1_key;
  logic [31:0]      m_drop, m_mis, m_total;

  int compared = 0;
  int mismatched = 0;

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs present before the edge.
  task automatic modelStep();
    int lvl;
    bit cand, hit;
    logic [CW-1:0] mn;
    if (!rst_n) begin
      mq.delete();
      for (int i = 0; i < DD; i++) md_val[i] = 0;
      md_ptr = 0; m_epoch = 0; m_run = 1;
      m_s1_valid = 0; m_s1_min = '0; m_s1_key = '0;
      m_drop = 0; m_mis = 0; m_total = 0;
      return;
    end
    lvl  = mq.size();
    cand = m_s1_valid && enable_i && threshold_i != 0 && m_s1_min >= threshold_i;
    hit  = 0;
    for (int i = 0; i < DD; i++) if (md_val[i] && md_key[i] == m_s1_key) hit = 1;
    if (clear_i) begin
      mq.delete();
      for (int i = 0; i < DD; i++) md_val[i] = 0;
      md_ptr = 0; m_epoch = 0; m_drop = 0; m_mis = 0; m_total = 0;
    end else begin
      if (lvl > 0 && hot_ready_i) mq.delete(0);
      if (m_run) begin
        if (m_epoch == EP - 1) begin
          m_epoch = 0;
          for (int i = 0; i < DD; i++) md_val[i] = 0;
        end else m_epoch++;
      end
      if (cand && !hit) begin
        if (lvl < FD) begin
          mq.push_back({m_s1_key, m_s1_min});
          m_total = sat(m_total);
          md_key[md_ptr] = m_s1_key;
          md_val[md_ptr] = 1;
          md_ptr = (md_ptr + 1) % DD;
        end else m_drop = sat(m_drop);
      end
      if (lane_valid_i != 0 && lane_valid_i != '1) m_mis = sat(m_mis);
    end
    mn = lane_cnt_i[CW-1:0];
    for (int i = 1; i < NL; i++) if (lane_cnt_i[i*CW +: CW] < mn) mn = lane_cnt_i[i*CW +: CW];
    m_s1_valid = &lane_valid_i;
    m_s1_min = mn;
    m_s1_key = lane_key_i;
    m_run = enable_i;
  endtask

  task automatic compareModel();
    checkOutput("model_hot_valid", hot_valid_o, mq.size() != 0);
    if (mq.size() != 0) begin
      checkOutput("model_hot_key", hot_key_o, mq[0][KW+CW-1:CW]);
      checkOutput("model_hot_cnt", hot_cnt_o, mq[0][CW-1:0]);
    end
    checkOutput("model_level", fifo_level_o, mq.size());
    checkOutput("model_drop", drop_cnt_o, m_drop);
    checkOutput("model_misalign", misalign_cnt_o, m_mis);
    checkOutput("model_total", hot_total_o, m_total);
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
    compareModel();
  endtask

  task automatic applyStimulus(input logic [NL-1:0] lv, input logic [NL*CW-1:0] cnt,
                               input logic [KW-1:0] key, input logic [CW-1:0] thr);
    lane_valid_i = lv;
    lane_cnt_i   = cnt;
    lane_key_i   = key;
    threshold_i  = thr;
  endtask

  task automatic setIdle();
    lane_valid_i = '0;
    lane_cnt_i   = '0;
    lane_key_i   = '0;
  endtask

  task automatic hotKey(input logic [KW-1:0] key);
    applyStimulus(4'b1111, {16'd20, 16'd20, 16'd20, 16'd20}, key, 16'd10);
    tick();
  endtask

  task automatic pulseClear();
    clear_i = 1'b1;
    setIdle();
    tick();
    clear_i = 1'b0;
  endtask

  typedef struct {
    logic [NL-1:0]    lv;
    logic [NL*CW-1:0] cnt;
    logic [KW-1:0]    key;
    logic [CW-1:0]    thr;
    bit               en;
    bit               exp_valid;
    logic [CW-1:0]    exp_cnt;
    logic [31:0]      exp_mis;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{4'b1111, {16'd12, 16'd7, 16'd9, 16'd5}, 32'h1000, 16'd5, 1, 1, 16'd5, 0};
    vecs[1] = '{4'b1111, {16'd12, 16'd7, 16'd9, 16'd3}, 32'h1001, 16'd5, 1, 0, 16'd0, 0};
    vecs[2] = '{4'b1111, {16'd9, 16'd9, 16'd9, 16'd9}, 32'h1002, 16'd0, 1, 0, 16'd0, 0};
    vecs[3] = '{4'b1011, {16'd9, 16'd9, 16'd9, 16'd9}, 32'h1003, 16'd5, 1, 0, 16'd0, 1};
    vecs[4] = '{4'b1111, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 32'h1004, 16'hFFFF, 1, 1, 16'hFFFF, 0};
    vecs[5] = '{4'b1111, {16'd100, 16'd150, 16'd200, 16'd100}, 32'h1005, 16'd100, 1, 1, 16'd100, 0};
    vecs[6] = '{4'b1111, {16'd100, 16'd150, 16'd200, 16'd99}, 32'h1006, 16'd100, 1, 0, 16'd0, 0};
    vecs[7] = '{4'b1111, {16'd50, 16'd50, 16'd50, 16'd50}, 32'h1007, 16'd5, 0, 0, 16'd0, 0};
    vecs[8] = '{4'b0000, {16'd50, 16'd50, 16'd50, 16'd50}, 32'h1008, 16'd5, 1, 0, 16'd0, 0};

    rst_n = 1'b0; enable_i = 1'b1; clear_i = 1'b0; hot_ready_i = 1'b0;
    threshold_i = '0;
    setIdle();
    tick();
    tick();
    checkOutput("reset_hot_valid", hot_valid_o, 0);
    checkOutput("reset_hot_key", hot_key_o, 0);
    checkOutput("reset_hot_cnt", hot_cnt_o, 0);
    checkOutput("reset_level", fifo_level_o, 0);
    checkOutput("reset_counters", {drop_cnt_o | misalign_cnt_o | hot_total_o}, 0);
    rst_n = 1'b1;
    tick();

    // Table vectors: one access each after a clear, checked two edges later.
    for (int v = 0; v < 9; v++) begin
      pulseClear();
      enable_i = vecs[v].en;
      applyStimulus(vecs[v].lv, vecs[v].cnt, vecs[v].key, vecs[v].thr);
      tick();
      setIdle();
      tick();
      checkOutput($sformatf("vec%0d_valid", v), hot_valid_o, vecs[v].exp_valid);
      if (vecs[v].exp_valid) begin
        checkOutput($sformatf("vec%0d_key", v), hot_key_o, vecs[v].key);
        checkOutput($sformatf("vec%0d_cnt", v), hot_cnt_o, vecs[v].exp_cnt);
      end
      checkOutput($sformatf("vec%0d_total", v), hot_total_o, vecs[v].exp_valid);
      checkOutput($sformatf("vec%0d_misalign", v), misalign_cnt_o, vecs[v].exp_mis);
      enable_i = 1'b1;
    end

    // Dedup: three back-to-back copies give one entry; after an epoch it reappears.
    pulseClear();
    for (int i = 0; i < 3; i++) hotKey(32'h2000);
    setIdle(); tick(); tick();
    checkOutput("dedup_level", fifo_level_o, 1);
    for (int i = 0; i < EP + 2; i++) tick();
    hotKey(32'h2000);
    setIdle(); tick(); tick();
    checkOutput("epoch_level", fifo_level_o, 2);

    // Overflow: 20 distinct keys with no drain, then drain in order.
    pulseClear();
    for (int i = 0; i < 20; i++) hotKey(32'h3000 + i);
    setIdle(); tick(); tick();
    checkOutput("full_level", fifo_level_o, 16);
    checkOutput("full_drop", drop_cnt_o, 4);
    checkOutput("full_total", hot_total_o, 16);
    hot_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("drain%0d_valid", i), hot_valid_o, 1);
      checkOutput($sformatf("drain%0d_key", i), hot_key_o, 32'h3000 + i);
      tick();
    end
    checkOutput("drain_empty", hot_valid_o, 0);
    hot_ready_i = 1'b0;

    // Clear while a hot key sits in stage 2, then a previously seen key is accepted.
    pulseClear();
    for (int i = 0; i < 3; i++) hotKey(32'h4000 + i);
    setIdle(); tick(); tick();
    checkOutput("pre_clear_level", fifo_level_o, 3);
    hotKey(32'h5000);
    pulseClear();
    checkOutput("clear_level", fifo_level_o, 0);
    checkOutput("clear_total", hot_total_o, 0);
    checkOutput("clear_valid", hot_valid_o, 0);
    tick();
    checkOutput("clear_no_push", fifo_level_o, 0);
    hotKey(32'h4000);
    setIdle(); tick(); tick();
    checkOutput("post_clear_level", fifo_level_o, 1);
    checkOutput("post_clear_key", hot_key_o, 32'h4000);

    // Disabled detection: hot traffic is ignored while existing entries drain.
    hotKey(32'h6000);
    hotKey(32'h6001);
    setIdle(); tick(); tick();
    checkOutput("pre_disable_level", fifo_level_o, 3);
    enable_i = 1'b0;
    hot_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) hotKey(32'h7000 + i);
    setIdle(); tick(); tick(); tick();
    checkOutput("disable_level", fifo_level_o, 0);
    checkOutput("disable_total", hot_total_o, 3);
    enable_i = 1'b1;
    hot_ready_i = 1'b0;

    // Randomized traffic against the model, including clears and resets.
    for (int n = 0; n < 3000; n++) begin
      logic [NL*CW-1:0] c;
      for (int l = 0; l < NL; l++) c[l*CW +: CW] = CW'($urandom_range(0, 40));
      applyStimulus(($urandom_range(0, 9) < 8) ? 4'b1111 : NL'($urandom_range(0, 15)), c,
                    32'h8000 + $urandom_range(0, 15),
                    ($urandom_range(0, 19) == 0) ? 16'd0 : CW'($urandom_range(1, 30)));
      hot_ready_i = ($urandom_range(0, 2) == 0);
      enable_i    = ($urandom_range(0, 9) != 0);
      clear_i     = ($urandom_range(0, 99) == 0);
      rst_n       = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1'b1;
    clear_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sketch_hot_filter.md
Name: sketch_hot_filter

Overview:
- Downstream consumer of the NUM_LANES count-min sketch lanes.
- Takes the per-lane counter reads for one access and forms the count-min estimate (minimum across lanes).
- Flags the key as hot when the estimate reaches a programmable threshold.
- Suppresses recently reported keys, then queues hot keys in a FIFO for the hot-page reporting logic (valid/ready drain).

Parameters:
NUM_LANES, 4, number of sketch lanes combined (>=1)
KEY_WIDTH, 32, key (page address) width
CNT_WIDTH, 16, per-lane counter width
FIFO_DEPTH, 16, hot-key FIFO entries (power of 2, >=2)
DEDUP_DEPTH, 8, recently-reported key table entries (>=1)
EPOCH_CYCLES, 65536, cycles between automatic dedup-table clears (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
enable_i  in  1  1 = detection active; 0 = no new pushes (FIFO still drains)
clear_i  in  1  one-cycle synchronous flush of FIFO, dedup table, statistics
threshold_i  in  CNT_WIDTH  hot threshold; 0 disables detection
lane_valid_i  in  NUM_LANES  per-lane valid_o from sketch lanes
lane_cnt_i  in  NUM_LANES*CNT_WIDTH  per-lane counts, lane i at [i*CNT_WIDTH +: CNT_WIDTH]
lane_key_i  in  KEY_WIDTH  key_o of lane 0
hot_valid_o  out  1  FIFO head valid
hot_ready_i  in  1  consumer accepts head
hot_key_o  out  KEY_WIDTH  head key
hot_cnt_o  out  CNT_WIDTH  head min-count estimate
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  occupancy
drop_cnt_o  out  32  hot keys dropped because FIFO full (saturating)
misalign_cnt_o  out  32  cycles with some but not all lane_valid_i set (saturating)
hot_total_o  out  32  hot keys pushed (saturating)

Behaviour:
- Reset (rst_n=0 at posedge): FIFO empty, hot_valid_o=0, hot_key_o=0, hot_cnt_o=0, fifo_level_o=0, all counters 0, dedup entries invalid, epoch timer 0, pipeline valids 0. Reset overrides clear_i and all traffic; mid-operation reset discards in-flight entries.
- Stage 1 (edge t+1):
  - s1_valid = AND of lane_valid_i.
  - s1_min = unsigned minimum of lane counts.
  - s1_key = lane_key_i.
  - Partial valid (nonzero, not all ones): s1_valid=0, misalign_cnt_o+1.
- Stage 2 (edge t+2), candidate = s1_valid && enable_i && threshold_i!=0 && s1_min>=threshold_i.
  - Candidate compared against all valid dedup entries.
  - Hit: discarded, no state change.
  - Miss, FIFO not full: push {key,min}; hot_total_o+1; key written into dedup table at round-robin pointer, overwriting oldest; pointer wraps at DEDUP_DEPTH-1.
  - Miss, FIFO full (level==FIFO_DEPTH at start of cycle, even if pop this cycle): drop, drop_cnt_o+1; dedup table unchanged.
- Latency: input at cycle t visible at hot_valid_o in cycle t+2 when FIFO empty.
- Back-to-back identical keys: second sees the first's dedup entry; no bypass needed.
- FIFO behaviour:
  - First-word-fall-through; head outputs driven from storage.
  - Pop when hot_valid_o && hot_ready_i.
  - Simultaneous push and pop: level unchanged.
  - hot_ready_i while empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH.
  - hot_key_o/hot_cnt_o hold their value while hot_valid_o=1 and hot_ready_i=0.
- Epoch timer:
  - Free-running counter.
  - At count EPOCH_CYCLES-1: wraps to 0 and invalidates all dedup entries that edge.
  - An insert in the same cycle takes precedence for its own entry (that entry remains valid).
- Control FSM, states RUN and IDLE:
  - RUN->IDLE when enable_i=0; IDLE->RUN when enable_i=1.
  - In IDLE the pipeline still advances (misalign counted), no pushes, epoch timer frozen.
- clear_i (either state):
  - Next edge: FIFO emptied, dedup invalidated, pointer/epoch/all counters zeroed.
  - Stage-2 push in that cycle is discarded.
  - State unchanged.
- Counters saturate at 32'hFFFF_FFFF.
- Width rules:
  - Compare is unsigned CNT_WIDTH.
  - Min of saturated lane counts (all ones) passes if threshold <= all-ones.

Test Plan:
- Reset then lanes all valid, counts {5,9,7,12}, key 0x1000, threshold 5 -> hot_valid_o high 2 cycles later, hot_key_o=0x1000, hot_cnt_o=5, hot_total_o=1.
- Counts {3,9,7,12}, threshold 5 -> no push; threshold 0 with counts {9,9,9,9} -> no push.
- Same hot key 0x2000 on 3 consecutive cycles -> exactly one FIFO entry. After EPOCH_CYCLES elapse, same key again -> second entry.
- hot_ready_i=0, 20 distinct hot keys (FIFO_DEPTH=16) -> level 16, drop_cnt_o=4. Then drain with hot_ready_i=1 -> 16 keys in arrival order, hot_valid_o falls after the last.
- lane_valid_i=4'b1011 for one cycle -> misalign_cnt_o=1, no push.
- FIFO holding 3 entries: clear_i pulse while a hot key sits in stage 2 -> level 0, counters 0, no push. The same key immediately after -> accepted (dedup cleared).
- enable_i=0 with hot traffic -> no pushes, existing entries still drain.
